// File: rtl/timer_seq_ctrl_if.sv
// picorv32 native memory bus slice seen by the timer sequencer register window.
interface timer_seq_ctrl_if;
  logic [31:0] addr;
  logic        wen;
  logic [31:0] wdata;
  logic        mem_valid;
  logic        mem_ready;
  logic [31:0] rdata;
  logic        ready;

  modport master (
    output addr, wen, wdata, mem_valid, mem_ready,
    input  rdata, ready
  );

  modport slave (
    input  addr, wen, wdata, mem_valid, mem_ready,
    output rdata, ready
  );
endinterface

// File: rtl/timer_seq_ctrl.sv
// Steps a timer through a programmed table of reload intervals, one entry per
// roll-over, with optional looping and a level interrupt at the end of each pass.
module timer_seq_ctrl #(
  parameter logic [31:0] ADDR        = 32'h0000_0000,
  parameter int unsigned NUM_ENTRIES = 4
) (
  input  logic              clk,
  input  logic              reset,
  timer_seq_ctrl_if.slave   bus,
  output logic [31:0]       tmr_value,
  output logic              tmr_en,
  output logic              tmr_go,
  output logic              tmr_auto_load,
  input  logic              tmr_int,
  output logic              irq
);

  localparam int unsigned IDX_W = 2;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_ENTRIES - 1);

  typedef enum logic [1:0] {IDLE, LOAD, RUN, NEXT} state_t;

  state_t           state;
  logic [IDX_W-1:0] idx;
  logic [IDX_W-1:0] len;
  logic             loop_en;
  logic             irq_en;
  logic             done;
  logic [31:0]      entry [NUM_ENTRIES];

  logic [31:0]      offset;
  logic [29:0]      word;
  logic             hit;
  logic             access;
  logic             wr;
  logic             ctrl_wr;
  logic             start_req;
  logic             abort_req;
  logic [IDX_W-1:0] len_eff;
  logic [31:0]      ctrl_rd;
  logic [31:0]      rd_val;
  logic [31:0]      load_val;

  // Word-aligned decode of CTRL plus the entry table; one ack per request.
  assign offset    = bus.addr - ADDR;
  assign word      = offset[31:2];
  assign hit       = (offset[1:0] == 2'b00) && (word <= 30'(NUM_ENTRIES));
  assign access    = bus.mem_valid && hit && !bus.mem_ready && !bus.ready;
  assign wr        = access && bus.wen;
  assign ctrl_wr   = wr && (word == 30'd0);
  assign start_req = ctrl_wr && bus.wdata[0];
  assign abort_req = ctrl_wr && bus.wdata[5];
  assign len_eff   = (len > LAST_IDX) ? LAST_IDX : len;

  assign ctrl_rd = {18'd0, idx, 2'b00, len, 3'b000,
                    (state != IDLE), done, irq_en, loop_en, 1'b0};

  assign tmr_auto_load = 1'b0;

  // Read mux and the table entry selected by the current index.
  always_comb begin
    rd_val   = ctrl_rd;
    load_val = 32'd0;
    for (int k = 0; k < NUM_ENTRIES; k++) begin
      if (word == 30'(k + 1)) rd_val = entry[k];
      if (idx == IDX_W'(k))   load_val = entry[k];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      idx       <= '0;
      len       <= '0;
      loop_en   <= 1'b0;
      irq_en    <= 1'b0;
      done      <= 1'b0;
      bus.rdata <= 32'd0;
      bus.ready <= 1'b0;
      tmr_value <= 32'd0;
      tmr_en    <= 1'b0;
      tmr_go    <= 1'b0;
      irq       <= 1'b0;
      for (int k = 0; k < NUM_ENTRIES; k++) entry[k] <= 32'd0;
    end else begin
      bus.ready <= access;
      if (access) bus.rdata <= rd_val;

      if (ctrl_wr) begin
        loop_en <= bus.wdata[1];
        irq_en  <= bus.wdata[2];
        len     <= bus.wdata[9:8];
        if (bus.wdata[3]) done <= 1'b0;
      end
      for (int k = 0; k < NUM_ENTRIES; k++) begin
        if (wr && word == 30'(k + 1)) entry[k] <= bus.wdata;
      end

      irq <= done && irq_en;

      // Abort overrides every state and any simultaneous start.
      if (abort_req) begin
        state  <= IDLE;
        tmr_en <= 1'b0;
        tmr_go <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            tmr_en <= 1'b0;
            tmr_go <= 1'b0;
            if (start_req) begin
              idx   <= '0;
              state <= LOAD;
            end
          end
          LOAD: begin
            tmr_value <= load_val;
            tmr_en    <= 1'b1;
            tmr_go    <= 1'b1;
            state     <= RUN;
          end
          RUN: begin
            tmr_go <= 1'b0;
            if (tmr_int) state <= NEXT;
          end
          NEXT: begin
            // Hardware set of DONE lands after the W1C above, so set wins.
            if (idx < len_eff) begin
              idx   <= idx + IDX_W'(1);
              state <= LOAD;
            end else begin
              done <= 1'b1;
              if (loop_en) begin
                idx   <= '0;
                state <= LOAD;
              end else begin
                tmr_en <= 1'b0;
                state  <= IDLE;
              end
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_timer_seq_ctrl.sv
// Bench for timer_seq_ctrl: behavioural timer model plus a queue of expected
// reload values consumed on every timer start pulse.
module tb_timer_seq_ctrl;

  localparam logic [31:0] BASE = 32'h0200_0000;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  timer_seq_ctrl_if bus ();
  logic [31:0] tmr_value;
  logic        tmr_en, tmr_go, tmr_auto_load, tmr_int, irq;
  logic        auto_int = 1'b0;
  logic        man_int  = 1'b0;

  assign tmr_int       = auto_int | man_int;
  assign bus.mem_ready = bus.ready;

  timer_seq_ctrl #(.ADDR(BASE), .NUM_ENTRIES(4)) dut (
    .clk           (clk),
    .reset         (reset),
    .bus           (bus),
    .tmr_value     (tmr_value),
    .tmr_en        (tmr_en),
    .tmr_go        (tmr_go),
    .tmr_auto_load (tmr_auto_load),
    .tmr_int       (tmr_int),
    .irq           (irq)
  );

  int          checks = 0;
  int          errors = 0;
  int          go_cnt = 0;
  int          tcnt   = 0;
  bit          auto_en = 1'b1;
  logic [31:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Every start pulse must match the next queued reload value.
  always @(negedge clk) begin
    if (tmr_go === 1'b1) begin
      go_cnt++;
      check("go_queued", 32'(exp_q.size() > 0), 32'd1);
      if (exp_q.size() > 0) check("go_value", tmr_value, exp_q.pop_front());
    end
  end

  // Timer model: one-cycle roll-over pulse 17 cycles after each start.
  always @(negedge clk) begin
    if (tmr_en !== 1'b1) begin
      tcnt = 0; auto_int = 1'b0;
    end else if (tmr_go === 1'b1) begin
      tcnt = 17; auto_int = 1'b0;
    end else if (tcnt > 0) begin
      tcnt--;
      auto_int = (tcnt == 0) && auto_en;
    end else begin
      auto_int = 1'b0;
    end
  end

  task automatic bus_access(input logic [31:0] a, input logic w, input logic [31:0] d,
                            output logic [31:0] rd, output logic ok);
    @(negedge clk);
    bus.addr = a; bus.wen = w; bus.wdata = d; bus.mem_valid = 1'b1;
    ok = 1'b0; rd = 32'd0;
    for (int i = 0; i < 4 && !ok; i++) begin
      @(posedge clk); #1;
      if (bus.ready) begin ok = 1'b1; rd = bus.rdata; end
    end
    bus.mem_valid = 1'b0; bus.wen = 1'b0;
  endtask

  task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
    logic [31:0] rd; logic ok;
    bus_access(a, 1'b1, d, rd, ok);
    check("write_ack", 32'(ok), 32'd1);
  endtask

  task automatic bus_read(input logic [31:0] a, output logic [31:0] rd);
    logic ok;
    bus_access(a, 1'b0, 32'd0, rd, ok);
    check("read_ack", 32'(ok), 32'd1);
  endtask

  task automatic wait_go(input int n);
    for (int i = 0; i < 300 && go_cnt < n; i++) @(negedge clk);
    check("wait_go", 32'(go_cnt), 32'(n));
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 300 && tmr_en !== 1'b0; i++) @(negedge clk);
    check("wait_idle", 32'(tmr_en), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout got=%0d exp=finish", checks);
    $fatal(1);
  end

  initial begin
    logic [31:0] rd;
    logic        ok;
    int          g;

    reset = 1'b1;
    bus.addr = 32'd0; bus.wen = 1'b0; bus.wdata = 32'd0; bus.mem_valid = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_tmr_en", 32'(tmr_en), 32'd0);
    check("rst_tmr_go", 32'(tmr_go), 32'd0);
    check("rst_irq", 32'(irq), 32'd0);
    check("rst_ready", 32'(bus.ready), 32'd0);
    check("rst_value", tmr_value, 32'd0);
    check("auto_load", 32'(tmr_auto_load), 32'd0);
    reset = 1'b0;

    // CTRL read with mem_valid held: ready must last exactly one cycle.
    @(negedge clk);
    bus.addr = BASE; bus.wen = 1'b0; bus.mem_valid = 1'b1;
    @(posedge clk); #1;
    check("rd_ready_hi", 32'(bus.ready), 32'd1);
    check("rd_ctrl_rst", bus.rdata, 32'd0);
    @(posedge clk); #1;
    check("rd_ready_lo", 32'(bus.ready), 32'd0);
    bus.mem_valid = 1'b0;

    // Addresses outside the window are not acknowledged.
    bus_access(BASE + 32'h14, 1'b1, 32'h1234_5678, rd, ok);
    check("undecoded", 32'(ok), 32'd0);

    // Single entry, interrupt enabled.
    g = go_cnt;
    bus_write(BASE + 32'h4, 32'hFFFF_FFF0);
    exp_q.push_back(32'hFFFF_FFF0);
    bus_write(BASE, 32'h0000_0005);
    wait_go(g + 1);
    wait_idle();
    repeat (2) @(negedge clk);
    check("single_irq", 32'(irq), 32'd1);
    bus_read(BASE, rd);
    check("single_ctrl", rd, 32'h0000_000C);
    bus_write(BASE, 32'h0000_000C);
    repeat (2) @(negedge clk);
    check("irq_cleared", 32'(irq), 32'd0);
    bus_read(BASE, rd);
    check("done_cleared", rd, 32'h0000_0004);

    // Three entries in table order, IDX visible while running.
    g = go_cnt;
    bus_write(BASE + 32'h4, 32'hFFFF_FFF0);
    bus_write(BASE + 32'h8, 32'hFFFF_FFE0);
    bus_write(BASE + 32'hC, 32'hFFFF_FF00);
    bus_read(BASE + 32'h8, rd);
    check("entry1_rb", rd, 32'hFFFF_FFE0);
    exp_q.push_back(32'hFFFF_FFF0);
    exp_q.push_back(32'hFFFF_FFE0);
    exp_q.push_back(32'hFFFF_FF00);
    bus_write(BASE, 32'h0000_0201);
    for (int k = 0; k < 3; k++) begin
      wait_go(g + k + 1);
      bus_read(BASE, rd);
      check("seq_ctrl_run", rd, (32'(k) << 12) | 32'h0000_0210);
    end
    wait_idle();
    bus_read(BASE, rd);
    check("seq_ctrl_done", rd, 32'h0000_2208);
    bus_write(BASE, 32'h0000_0208);

    // Looping two-entry table; LOOP cleared in the second pass.
    g = go_cnt;
    bus_write(BASE + 32'h4, 32'hFFFF_FF80);
    bus_write(BASE + 32'h8, 32'hFFFF_FF40);
    for (int p = 0; p < 2; p++) begin
      exp_q.push_back(32'hFFFF_FF80);
      exp_q.push_back(32'hFFFF_FF40);
    end
    bus_write(BASE, 32'h0000_0103);
    wait_go(g + 3);
    bus_read(BASE, rd);
    check("loop_done_pass1", rd, 32'h0000_011A);
    wait_go(g + 4);
    bus_write(BASE, 32'h0000_0100);
    wait_idle();
    check("loop_go_total", 32'(go_cnt), 32'(g + 4));
    bus_read(BASE, rd);
    check("loop_ctrl_end", rd, 32'h0000_1108);
    bus_write(BASE, 32'h0000_0108);

    // Abort during RUN; start while busy and start|abort are ignored.
    g = go_cnt;
    bus_write(BASE + 32'h4, 32'hFFFF_FFF0);
    exp_q.push_back(32'hFFFF_FFF0);
    bus_write(BASE, 32'h0000_0001);
    wait_go(g + 1);
    bus_write(BASE, 32'h0000_0001);
    check("busy_start_en", 32'(tmr_en), 32'd1);
    bus_write(BASE, 32'h0000_0020);
    check("abort_en", 32'(tmr_en), 32'd0);
    check("abort_go", 32'(tmr_go), 32'd0);
    bus_read(BASE, rd);
    check("abort_ctrl", rd, 32'h0000_0000);
    bus_write(BASE, 32'h0000_0021);
    repeat (5) @(negedge clk);
    check("startabort_en", 32'(tmr_en), 32'd0);
    check("startabort_go", 32'(go_cnt), 32'(g + 1));
    bus_read(BASE, rd);
    check("startabort_ctrl", rd, 32'h0000_0000);

    // Roll-over lands in NEXT on the same edge as a DONE W1C: set wins.
    auto_en = 1'b0;
    g = go_cnt;
    exp_q.push_back(32'hFFFF_FFF0);
    bus_write(BASE, 32'h0000_0001);
    wait_go(g + 1);
    repeat (3) @(negedge clk);
    man_int = 1'b1;
    @(negedge clk);
    man_int = 1'b0;
    bus.addr = BASE; bus.wen = 1'b1; bus.wdata = 32'h0000_0008; bus.mem_valid = 1'b1;
    @(posedge clk); #1;
    check("w1c_race_ack", 32'(bus.ready), 32'd1);
    bus.mem_valid = 1'b0; bus.wen = 1'b0;
    bus_read(BASE, rd);
    check("w1c_race_done", rd, 32'h0000_0008);
    check("w1c_race_en", 32'(tmr_en), 32'd0);
    bus_write(BASE, 32'h0000_0008);
    auto_en = 1'b1;

    // Asynchronous reset in the middle of RUN.
    g = go_cnt;
    exp_q.push_back(32'hFFFF_FFF0);
    bus_write(BASE, 32'h0000_0005);
    wait_go(g + 1);
    repeat (3) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    check("arst_en", 32'(tmr_en), 32'd0);
    check("arst_go", 32'(tmr_go), 32'd0);
    check("arst_value", tmr_value, 32'd0);
    check("arst_irq", 32'(irq), 32'd0);
    check("arst_rdata", bus.rdata, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    bus_read(BASE, rd);
    check("arst_ctrl", rd, 32'h0000_0000);

    repeat (25) @(negedge clk);
    check("queue_empty", 32'(exp_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/timer_seq_ctrl.md
Name: timer_seq_ctrl

Overview:
- Sequencer that drives one `timer` instance: enable, go, reload value and auto-load.
- Steps the timer through a software-programmed table of up to NUM_ENTRIES interval values, one entry per timer roll-over.
- Optionally loops over the table, and raises a level interrupt when a sequence pass completes.
- Sits on the picorv32 native memory bus as a small register window, alongside the existing timer block.

Parameters:
- ADDR, 32'h0000_0000, base byte address of register window; must be set at instantiation.
- NUM_ENTRIES, 4, number of interval table entries; legal values 1..4.

Ports:
- clk, input, 1, system clock.
- reset, input, 1, asynchronous active-high reset.
- addr, input, 32, bus byte address.
- wen, input, 1, bus write enable; any nonzero byte strobe counts as a write.
- wdata, input, 32, bus write data.
- mem_valid, input, 1, bus request valid.
- mem_ready, input, 1, OR of the bus ready signals.
- rdata, output, 32, registered read data.
- ready, output, 1, access acknowledge.
- tmr_value, output, 32, load value to the timer.
- tmr_en, output, 1, timer enable.
- tmr_go, output, 1, timer start pulse.
- tmr_auto_load, output, 1, tied 0; reloading is done by this block.
- tmr_int, input, 1, timer roll-over pulse, 1 cycle.
- irq, output, 1, sequence-done interrupt, level.

Behaviour:
- Reset: asynchronous, active-high. Clears all registers, FSM state IDLE, idx 0, and every output: rdata, ready, tmr_value, tmr_en, tmr_go, irq.
- Register map (word offsets from ADDR):
  - +0x0 CTRL.
  - +0x4 + 4*k ENTRY[k], k < NUM_ENTRIES; 32-bit R/W.
  - Other addresses are not decoded and get no ready.
- CTRL bits:
  - b0 START: write-1 pulse, reads 0.
  - b1 LOOP: R/W.
  - b2 IRQ_EN: R/W.
  - b3 DONE: set by hardware, write-1-to-clear.
  - b4 BUSY: read-only, 1 when FSM is not IDLE.
  - b5 ABORT: write-1 pulse, reads 0.
  - b9:8 LEN: R/W, sequence length minus 1; values ≥ NUM_ENTRIES are treated as NUM_ENTRIES-1.
  - b13:12 IDX: read-only, current entry.
- Bus handshake:
  - On mem_valid with a decoded address and mem_ready low, ready=1 for exactly one cycle on the next edge, with rdata valid in the same cycle.
  - A write takes effect on that same edge.
  - ready returns to 0 the following cycle even if mem_valid is still high.
- FSM:
  - IDLE: tmr_en=0, tmr_go=0. START → LOAD, with idx←0.
  - LOAD (1 cycle): tmr_value←ENTRY[idx], tmr_en←1, tmr_go←1 (registered, so go is high during the next state) → RUN.
  - RUN: tmr_go←0. On tmr_int → NEXT.
  - NEXT (1 cycle; lets the timer pass ROLL→IDLE):
    - If idx < LEN: idx←idx+1 → LOAD.
    - Else DONE←1, then:
      - if LOOP: idx←0 → LOAD;
      - otherwise → IDLE, tmr_en←0.
- Latency:
  - START write edge to tmr_go high: 2 cycles.
  - tmr_int to next tmr_go high: 3 cycles.
- irq = DONE & IRQ_EN, registered. It stays high until DONE is cleared or IRQ_EN is written 0.
- Boundary cases:
  - START while BUSY: ignored.
  - ABORT in any state: FSM→IDLE, tmr_en←0, tmr_go←0 on that edge; DONE unchanged.
  - ABORT and START in the same write: ABORT wins.
  - DONE set by hardware and W1C in the same cycle: set wins.
  - ENTRY write while running: used at the next LOAD of that index; the current interval is unaffected.
  - tmr_int outside RUN: ignored.
  - LOOP cleared during RUN: the sequence stops after the current pass completes.
  - Reset mid-sequence: immediate return to reset values, timer disabled.

Test Plan:
- Reset, then read CTRL at ADDR → rdata=0, ready high exactly 1 cycle, irq=0, tmr_en=0.
- ENTRY0=32'hFFFF_FFF0, LEN=0, IRQ_EN=1, START → tmr_go pulse with tmr_value=FFFF_FFF0. Model timer tmr_int 17 cycles later → DONE=1, irq=1, BUSY=0, tmr_en=0. Write CTRL b3=1 → irq=0.
- ENTRY0..2 = FFFF_FFF0 / FFFF_FFE0 / FFFF_FF00, LEN=2 → three go pulses in table order with those values. DONE is set only after the third tmr_int; IDX reads 0,1,2 across the run.
- LOOP=1, LEN=1 → go pulse values alternate E0,E1,E0,E1; DONE set after each second roll-over. Clear LOOP mid-run → stops at the end of the pass.
- ABORT during RUN → tmr_en=0 next edge, BUSY=0. START issued while BUSY → no extra tmr_go. START|ABORT in one write → stays IDLE.
- Raise tmr_int in NEXT on the same cycle software writes DONE W1C → DONE stays 1. Assert reset mid-RUN → all outputs 0 asynchronously.
